// File: rtl/sort_pe.sv
// sort_pe: systolic odd-even sort PE holding a signed pair (a, b) with a multi-cycle compare-and-swap (optional SORT_PE_PROTO_CHECK_EN adds sticky proto_err)
module sort_pe #(
  parameter int FIX_POINT_WIDTH = 16,
  parameter int CMP_LAT         = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_en,
  input  logic [FIX_POINT_WIDTH-1:0] load_a,
  input  logic [FIX_POINT_WIDTH-1:0] load_b,
  input  logic                       SL,
  input  logic                       SR,
  input  logic                       RL,
  input  logic                       RR,
  input  logic                       cmp_en,
  input  logic [FIX_POINT_WIDTH-1:0] left_in,
  input  logic [FIX_POINT_WIDTH-1:0] right_in,
  output logic [FIX_POINT_WIDTH-1:0] left_out,
  output logic                       left_out_valid,
  output logic [FIX_POINT_WIDTH-1:0] right_out,
  output logic                       right_out_valid,
  output logic [FIX_POINT_WIDTH-1:0] a_out,
  output logic [FIX_POINT_WIDTH-1:0] b_out,
  output logic                       busy,
`ifdef SORT_PE_PROTO_CHECK_EN
  output logic                       proto_err,
`endif
  output logic                       cmp_done
);
  typedef enum logic [1:0] {IDLE, CMP, WRITE} state_t;
  localparam logic [3:0] LAST = 4'(CMP_LAT - 1);
  state_t state_q, state_d;
  logic [FIX_POINT_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, cmp_done_q, cmp_done_d;
  logic left_out_valid_q, left_out_valid_d, right_out_valid_q, right_out_valid_d;
  logic cmp_en_q, cmp_en_d, armed_q, armed_d;
  logic start;
  // armed blocks a compare until cmp_en has been seen low after reset
  assign start = cmp_en && !cmp_en_q && armed_q;
  // next-state: load beats receive, receive (idle only) beats compare
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    state_d = state_q;
    cnt_d = cnt_q;
    cmp_done_d = 1'b0;
    if (load_en) begin
      a_d = load_a;
      b_d = load_b;
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          a_d = RL ? left_in : a_q;
          b_d = RR ? right_in : b_q;
          state_d = start ? CMP : IDLE;
          cnt_d = start ? 4'd1 : cnt_q;
        end
        CMP: begin
          state_d = (cnt_q == LAST) ? WRITE : CMP;
          cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 4'd1;
        end
        WRITE: begin
          a_d = ($signed(a_q) > $signed(b_q)) ? b_q : a_q;
          b_d = ($signed(a_q) > $signed(b_q)) ? a_q : b_q;
          cmp_done_d = 1'b1;
          state_d = IDLE;
          cnt_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d != IDLE;
    left_out_valid_d = SL;
    right_out_valid_d = SR;
    cmp_en_d = cmp_en;
    armed_d = armed_q | ~cmp_en;
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      cmp_done_q <= 1'b0;
      left_out_valid_q <= 1'b0;
      right_out_valid_q <= 1'b0;
      cmp_en_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      cmp_done_q <= cmp_done_d;
      left_out_valid_q <= left_out_valid_d;
      right_out_valid_q <= right_out_valid_d;
      cmp_en_q <= cmp_en_d;
      armed_q <= armed_d;
    end
  end
  assign left_out = a_q;
  assign right_out = b_q;
  assign a_out = a_q;
  assign b_out = b_q;
  assign left_out_valid = left_out_valid_q;
  assign right_out_valid = right_out_valid_q;
  assign busy = busy_q;
  assign cmp_done = cmp_done_q;
`ifdef SORT_PE_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;
  // sticky flag for strobe misuse
  always_comb begin
    proto_err_d = proto_err_q | (busy_q & (RL | RR)) | (busy_q & cmp_en & ~cmp_en_q) | (SL & RL) | (SR & RR);
  end
  // proto_err register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err_q <= 1'b0;
    else proto_err_q <= proto_err_d;
  end
  assign proto_err = proto_err_q;
`endif
endmodule

// File: doc/sort_pe.md
Name: sort_pe

Overview:
- Processing element that acts as the responder for the systolic odd-even sort controller.
- Holds one signed fixed-point pair (a, b).
- Executes the controller's send-left/send-right/receive-left/receive-right strobes against its neighbours.
- Performs a multi-cycle compare-and-swap so that a <= b; a linear chain of these PEs forms the sort array.

Parameters:
- FIX_POINT_WIDTH, 16, width of each signed two's-complement element.
- CMP_LAT, 6, cycles from compare start to result update (legal 2..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  write pair from load_a/load_b (controller write_enable)
- load_a  in  FIX_POINT_WIDTH  initial a
- load_b  in  FIX_POINT_WIDTH  initial b
- SL  in  1  send-left strobe
- SR  in  1  send-right strobe
- RL  in  1  receive-from-left strobe
- RR  in  1  receive-from-right strobe
- cmp_en  in  1  compare enable (level, held by controller)
- left_in  in  FIX_POINT_WIDTH  left neighbour's right_out
- right_in  in  FIX_POINT_WIDTH  right neighbour's left_out
- left_out  out  FIX_POINT_WIDTH  always a_reg
- left_out_valid  out  1  registered SL
- right_out  out  FIX_POINT_WIDTH  always b_reg
- right_out_valid  out  1  registered SR
- a_out  out  FIX_POINT_WIDTH  a_reg (result readout)
- b_out  out  FIX_POINT_WIDTH  b_reg
- busy  out  1  compare in progress
- cmp_done  out  1  one-cycle pulse, result written

Behaviour:
- Reset (async, rst_n=0): a_reg=b_reg=0, FSM=IDLE, cnt=0, busy=0, cmp_done=0, left_out_valid=right_out_valid=0, cmp_en_d=0.
- Send:
  - left_out/right_out are direct register outputs, so data is present in the same cycle the neighbour samples RL/RR.
  - *_out_valid = SL/SR delayed one cycle; informational only.
- Receive: at the clock edge where RL=1, a_reg <= left_in; where RR=1, b_reg <= right_in. Both may be high in one cycle and both update.
- Simultaneous send and receive on the same side: the neighbour sees the old value; the register takes the new value at the edge.
- Priority at each edge:
  - load_en first: a<=load_a, b<=load_b, FSM forced IDLE, cnt cleared.
  - then receive strobes, accepted only when FSM=IDLE.
  - then compare.
- Compare start: rising edge of cmp_en (cmp_en=1 and cmp_en_d=0) while IDLE -> CMP, cnt<=1, busy=1 from the next cycle.
- A held-high cmp_en does not retrigger; cmp_en must drop for at least one cycle before the next compare.
- FSM states:
  - IDLE: wait for compare start.
  - CMP: cnt increments each cycle; at cnt==CMP_LAT-1 -> WRITE.
  - WRITE: if a_reg > b_reg (signed), swap; cmp_done=1; -> IDLE.
- Timing: result visible and cmp_done=1 exactly CMP_LAT cycles after the start edge; busy=1 during CMP and WRITE.
- Equal values: no swap.
- Extremes: full signed range; no arithmetic widening (comparison only).
- During busy: RL/RR are ignored, and a/b stay stable for the comparison. SL/SR still drive outputs.
- cmp_en falling mid-compare: the compare still completes.
- Reset mid-compare: immediate return to reset state; no cmp_done.

Optional Feature:
- Macro SORT_PE_PROTO_CHECK_EN.
- Defined:
  - Adds output proto_err (1 bit, reset 0, sticky until reset).
  - Set when RL or RR is sampled while busy.
  - Set when cmp_en rises while busy.
  - Set when SL and RL are both high in one cycle.
  - Set when SR and RR are both high in one cycle.
- Undefined: port absent; those conditions are silently handled as above.

Test Plan:
- Reset then load_en with a=0x0005, b=0x0003; raise cmp_en and hold 8 cycles -> cmp_done pulses 6 cycles after the start edge; a_out=0x0003, b_out=0x0005; busy high 6 cycles; no second compare.
- Load a=0xFFF0 (-16), b=0x0002, compare -> no swap; a=0xFFF0, b=0x0002. Load a=0x7FFF, b=0x8000, compare -> a=0x8000, b=0x7FFF.
- Load (7,7), compare -> unchanged; cmp_done still pulses once.
- Two chained PEs. PE0 SR with PE1 RL in the same cycle, PE0 b=0x0009 -> PE1 a=0x0009 next cycle; PE0 right_out_valid=1 one cycle after SR.
- Start a compare on (9,1), assert RR with right_in=0x0004 during busy -> b unchanged until swap; result a=1, b=9. With SORT_PE_PROTO_CHECK_EN, proto_err=1 and stays 1.
- Deassert rst_n at cycle 3 of a compare -> all outputs 0 asynchronously; after release, cmp_en already high causes no start until it falls and rises again.
